// File: rtl/queue_sync_if.sv
// queue_sync_if: FIFO handshake/status bundle for queue_sync.
// master = producer/consumer side, slave = the queue itself.
interface queue_sync_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic             clr;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [LW-1:0]    level;
    logic             overflow;
    logic             underflow;

    modport master (
        output clr, wr_en, wr_data, rd_en,
        input  rd_data, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );

    modport slave (
        input  clr, wr_en, wr_data, rd_en,
        output rd_data, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );
endinterface

// File: rtl/queue_sync.sv
// queue_sync: single-clock parametrised FIFO for USB endpoint buffering.
// All DEPTH entries usable, occupancy level, almost flags, synchronous flush,
// sticky overflow/underflow.
// Build option: define QUEUE_SYNC_FWFT_EN for first-word-fall-through reads
// (combinational rd_data from distributed RAM); default is a registered read
// from block RAM.
module queue_sync #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 64,
    parameter int AFULL_LEVEL  = 56,
    parameter int AEMPTY_LEVEL = 8
) (
    input logic          clk,
    input logic          rst,
    queue_sync_if.slave  q
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

`ifdef QUEUE_SYNC_FWFT_EN
    (* ram_style = "distributed" *) logic [WIDTH-1:0] mem [DEPTH];
`else
    (* ram_style = "block" *) logic [WIDTH-1:0] mem [DEPTH];
`endif

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW-1:0] cnt;
    logic          ovf;
    logic          unf;
    logic          full_i;
    logic          empty_i;
    logic          wr_acc;
    logic          rd_acc;

    assign full_i  = (cnt == PW'(DEPTH));
    assign empty_i = (cnt == '0);
    assign wr_acc  = q.wr_en & ~full_i;
    assign rd_acc  = q.rd_en & ~empty_i;

    // Pointers, occupancy and sticky error flags; clr outranks any request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            ovf  <= 1'b0;
            unf  <= 1'b0;
        end else if (q.clr) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            ovf  <= 1'b0;
            unf  <= 1'b0;
        end else begin
            if (wr_acc) wptr <= wptr + PW'(1);
            if (rd_acc) rptr <= rptr + PW'(1);
            case ({wr_acc, rd_acc})
                2'b10:   cnt <= cnt + PW'(1);
                2'b01:   cnt <= cnt - PW'(1);
                default: cnt <= cnt;
            endcase
            if (q.wr_en && full_i)  ovf <= 1'b1;
            if (q.rd_en && empty_i) unf <= 1'b1;
        end
    end

    // Storage write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_acc && !q.clr) mem[wptr[AW-1:0]] <= q.wr_data;
    end

`ifdef QUEUE_SYNC_FWFT_EN
    assign q.rd_data = mem[rptr[AW-1:0]];
`else
    logic [WIDTH-1:0] rd_q;

    // Registered read: head word captured on the edge of an accepted read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q <= '0;
        end else if (q.clr) begin
            rd_q <= '0;
        end else if (rd_acc) begin
            rd_q <= mem[rptr[AW-1:0]];
        end
    end

    assign q.rd_data = rd_q;
`endif

    assign q.full         = full_i;
    assign q.empty        = empty_i;
    assign q.almost_full  = (cnt >= PW'(AFULL_LEVEL));
    assign q.almost_empty = (cnt <= PW'(AEMPTY_LEVEL));
    assign q.level        = cnt;
    assign q.overflow     = ovf;
    assign q.underflow    = unf;
endmodule
